// File: rtl/ifetch_ir_if.sv
// Fetch-stage bundle: instruction-memory handshake, redirect/stall control and decoded IR fields.
// The master modport is the fetch stage itself; slave is memory plus the downstream pipeline.
interface ifetch_ir_if;
  logic [31:0] Imem_Addr;
  logic        Imem_Req;
  logic        Imem_Ack;
  logic [31:0] Imem_Data;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        Inst_Valid;
  logic [31:0] Inst;
  logic [31:0] PC_Out;
  logic [31:0] PC4;
  logic [5:0]  Op;
  logic [5:0]  Func;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [4:0]  Shamt;
  logic [15:0] Imm16;
  logic        Se;

  modport master (
    output Imem_Addr, Imem_Req, Inst_Valid, Inst, PC_Out, PC4,
           Op, Func, Rs, Rt, Rd, Shamt, Imm16, Se,
    input  Imem_Ack, Imem_Data, Stall, Redirect, Redirect_PC
  );

  modport slave (
    input  Imem_Addr, Imem_Req, Inst_Valid, Inst, PC_Out, PC4,
           Op, Func, Rs, Rt, Rd, Shamt, Imm16, Se,
    output Imem_Ack, Imem_Data, Stall, Redirect, Redirect_PC
  );
endinterface

// File: rtl/ifetch_ir.sv
// MIPS instruction fetch + instruction register: owns the PC, req/ack handshake with imem,
// holds the fetched word under Stall and splits it into decode fields.
module ifetch_ir #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  ifetch_ir_if.master bus
);

  typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;

  logic req;
  logic capture;

  // Requesting in ISSUE only when the held instruction leaves this cycle.
  assign req     = ~Reset & ((state_q == FETCH) | ((state_q == ISSUE) & ~bus.Stall));
  assign capture = req & bus.Imem_Ack & ~bus.Redirect;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    if (bus.Redirect) begin
      pc_d    = bus.Redirect_PC & 32'hFFFF_FFFC;
      state_d = FETCH;
    end else if (capture) begin
      inst_d   = bus.Imem_Data;
      pc_out_d = pc_q;
      pc_d     = pc_q + 32'd4;
      state_d  = ISSUE;
    end else if ((state_q == ISSUE) && !bus.Stall) begin
      state_d = FETCH;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      inst_q   <= 32'h0;
      pc_out_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
    end
  end

  logic se;
  always_comb begin
    se = 1'b0;
    case (inst_q[31:26])
      6'b000100, 6'b000101, 6'b001000, 6'b001001,
      6'b001010, 6'b001011, 6'b100011, 6'b101011: se = 1'b1;
      default:                                    se = 1'b0;
    endcase
  end

  assign bus.Imem_Addr  = pc_q;
  assign bus.Imem_Req   = req;
  assign bus.Inst_Valid = (state_q == ISSUE);
  assign bus.Inst       = inst_q;
  assign bus.PC_Out     = pc_out_q;
  assign bus.PC4        = pc_out_q + 32'd4;
  assign bus.Op         = inst_q[31:26];
  assign bus.Rs         = inst_q[25:21];
  assign bus.Rt         = inst_q[20:16];
  assign bus.Rd         = inst_q[15:11];
  assign bus.Shamt      = inst_q[10:6];
  assign bus.Func       = inst_q[5:0];
  assign bus.Imm16      = inst_q[15:0];
  assign bus.Se         = se;

endmodule

// File: tb/tb_ifetch_ir.sv
// Directed bench for ifetch_ir: reset, zero-wait streaming, delayed ack, stall, redirect,
// PC wrap from RESET_PC=FFFF_FFFC, and asynchronous reset during a stall.
module tb_ifetch_ir;

  logic Clk;
  logic Reset;
  int   checks;
  int   failures;

  ifetch_ir_if bus0 ();
  ifetch_ir_if bus1 ();

  ifetch_ir #(.RESET_PC(32'h0000_0000)) dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0));
  ifetch_ir #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h2008_FFFF;  // addi $8,$0,-1
      32'h0000_0004: mem_word = 32'h3409_FFFF;  // ori  $9,$0,0xFFFF
      32'h0000_0008: mem_word = 32'h8D2A_0010;  // lw   $10,16($9)
      32'h0000_000C: mem_word = 32'h012A_5820;  // add  $11,$9,$10
      32'h0000_0100: mem_word = 32'h1109_FFFE;  // beq
      default:       mem_word = {16'hDEAD, a[15:0]};
    endcase
  endfunction

  always_comb bus0.Imem_Data = mem_word(bus0.Imem_Addr);
  always_comb bus1.Imem_Data = mem_word(bus1.Imem_Addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    bus0.Imem_Ack = 1'b0; bus0.Stall = 1'b0; bus0.Redirect = 1'b0; bus0.Redirect_PC = 32'h0;
    bus1.Imem_Ack = 1'b1; bus1.Stall = 1'b0; bus1.Redirect = 1'b0; bus1.Redirect_PC = 32'h0;

    // Reset state
    tick();
    chk("rst_valid", 32'(bus0.Inst_Valid), 32'd0);
    chk("rst_req",   32'(bus0.Imem_Req),   32'd0);
    chk("rst_addr",  bus0.Imem_Addr,       32'h0);
    chk("rst_inst",  bus0.Inst,            32'h0);
    chk("rst_pcout", bus0.PC_Out,          32'h0);
    chk("rst_pc4",   bus0.PC4,             32'd4);
    chk("rst_se",    32'(bus0.Se),         32'd0);
    chk("rst_addr1", bus1.Imem_Addr,       32'hFFFF_FFFC);
    chk("rst_req1",  32'(bus1.Imem_Req),   32'd0);

    // Zero-wait streaming
    bus0.Imem_Ack = 1'b1;
    Reset = 1'b0;
    #1;
    chk("first_req",  32'(bus0.Imem_Req), 32'd1);
    chk("first_addr", bus0.Imem_Addr,     32'h0);
    tick();
    chk("c1_valid", 32'(bus0.Inst_Valid), 32'd1);
    chk("c1_pcout", bus0.PC_Out,          32'h0);
    chk("c1_imm",   32'(bus0.Imm16),      32'hFFFF);
    chk("c1_se",    32'(bus0.Se),         32'd1);
    chk("c1_rt",    32'(bus0.Rt),         32'd8);
    chk("c1_op",    32'(bus0.Op),         32'h08);
    chk("c1_addr",  bus0.Imem_Addr,       32'h4);
    chk("wrap_pcout", bus1.PC_Out,        32'hFFFF_FFFC);
    chk("wrap_pc4",   bus1.PC4,           32'h0);
    chk("wrap_addr",  bus1.Imem_Addr,     32'h0);
    bus0.Imem_Ack = 1'b0;
    #0;
    tick();
    // Ack was removed right after cycle 1, but the ack for addr 4 was sampled? No: it was dropped before this edge.
    chk("c2_valid", 32'(bus0.Inst_Valid), 32'd0);
    chk("c2_pcout", bus0.PC_Out,          32'h0);
    chk("wrap_2nd", bus1.PC_Out,          32'h0);

    // Refetch addr 4 with ack, then check cycle-2 style fields
    bus0.Imem_Ack = 1'b1;
    tick();
    chk("i4_pcout", bus0.PC_Out,    32'h4);
    chk("i4_op",    32'(bus0.Op),   32'h0D);
    chk("i4_se",    32'(bus0.Se),   32'd0);
    chk("i4_pc4",   bus0.PC4,       32'h8);

    // Ack delayed 3 cycles
    bus0.Imem_Ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dly_valid", 32'(bus0.Inst_Valid), 32'd0);
      chk("dly_req",   32'(bus0.Imem_Req),   32'd1);
      chk("dly_addr",  bus0.Imem_Addr,       32'h8);
    end
    bus0.Imem_Ack = 1'b1;
    tick();
    chk("dly_got",   32'(bus0.Inst_Valid), 32'd1);
    chk("dly_inst",  bus0.Inst,            32'h8D2A_0010);
    chk("dly_pcout", bus0.PC_Out,          32'h8);
    chk("lw_se",     32'(bus0.Se),         32'd1);

    // Stall held 4 cycles
    bus0.Stall = 1'b1;
    #1;
    chk("stl_req0", 32'(bus0.Imem_Req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stl_inst",  bus0.Inst,            32'h8D2A_0010);
      chk("stl_pcout", bus0.PC_Out,          32'h8);
      chk("stl_valid", 32'(bus0.Inst_Valid), 32'd1);
      chk("stl_req",   32'(bus0.Imem_Req),   32'd0);
      chk("stl_addr",  bus0.Imem_Addr,       32'hC);
    end
    bus0.Stall = 1'b0;
    #1;
    chk("rel_req",  32'(bus0.Imem_Req), 32'd1);
    chk("rel_addr", bus0.Imem_Addr,     32'hC);
    tick();
    chk("add_inst", bus0.Inst,          32'h012A_5820);
    chk("add_rs",   32'(bus0.Rs),       32'd9);
    chk("add_rt",   32'(bus0.Rt),       32'd10);
    chk("add_rd",   32'(bus0.Rd),       32'd11);
    chk("add_func", 32'(bus0.Func),     32'h20);
    chk("add_sh",   32'(bus0.Shamt),    32'd0);
    chk("add_se",   32'(bus0.Se),       32'd0);

    // Redirect with ack in the same cycle
    bus0.Redirect    = 1'b1;
    bus0.Redirect_PC = 32'h0000_0103;
    tick();
    bus0.Redirect = 1'b0;
    #1;
    chk("rd_valid", 32'(bus0.Inst_Valid), 32'd0);
    chk("rd_addr",  bus0.Imem_Addr,       32'h100);
    chk("rd_inst",  bus0.Inst,            32'h012A_5820);
    chk("rd_pcout", bus0.PC_Out,          32'hC);
    tick();
    chk("rd_next_pc",   bus0.PC_Out, 32'h100);
    chk("rd_next_inst", bus0.Inst,   32'h1109_FFFE);
    chk("beq_se",       32'(bus0.Se), 32'd1);

    // Redirect wins over Stall
    bus0.Stall       = 1'b1;
    bus0.Redirect    = 1'b1;
    bus0.Redirect_PC = 32'h0000_0004;
    tick();
    bus0.Redirect = 1'b0;
    bus0.Stall    = 1'b0;
    #1;
    chk("rs_valid", 32'(bus0.Inst_Valid), 32'd0);
    chk("rs_addr",  bus0.Imem_Addr,       32'h4);
    tick();
    chk("rs_pcout", bus0.PC_Out, 32'h4);
    chk("rs_inst",  bus0.Inst,   32'h3409_FFFF);

    // Asynchronous reset during a stalled ISSUE
    bus0.Stall = 1'b1;
    #2;
    Reset = 1'b1;
    #1;
    chk("ar_valid", 32'(bus0.Inst_Valid), 32'd0);
    chk("ar_inst",  bus0.Inst,            32'h0);
    chk("ar_pcout", bus0.PC_Out,          32'h0);
    chk("ar_addr",  bus0.Imem_Addr,       32'h0);
    chk("ar_req",   32'(bus0.Imem_Req),   32'd0);
    chk("ar_pc4",   bus0.PC4,             32'd4);
    chk("ar_addr1", bus1.Imem_Addr,       32'hFFFF_FFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
